// File: rtl/acc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// acc_seq_ctrl
//
// Accelerator-side sequencer behind the host datapath register block. A rising
// edge of START (while STOP is low, and only from IDLE) snapshots the host input
// word. The snapshot is streamed to the TM core as CHUNK_W-bit beats, LSB slice
// first, over a valid/ready handshake. The sequencer then waits for the core
// result and hands it back to the register block with a one-cycle capture
// strobe. STOP, or a result timeout, aborts the job and pulses core_clear once.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start, stop       START / STOP levels from the control register
//   in_data_reg       host input word (IN_WIDTH bits)
//   core_in_*         beat stream to the core (valid/ready/data/last)
//   core_res_*        result handshake from the core
//   core_clear        one-cycle core flush pulse on abort
//   out_data_cap_en   one-cycle capture strobe to the register block
//   acc_out_data      last captured result, held until next capture or reset
//   seq_busy          high whenever the sequencer is not idle
//   timeout_err       sticky result-timeout flag, cleared by the next launch
//
// IN_WIDTH must be an integer multiple of CHUNK_W; TIMEOUT_CYC must be >= 1.
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a START rising edge
// LOAD     | presenting snapshot beats to the core
// WAIT_RES | all beats accepted, waiting for the core result
// CAPTURE  | one-cycle strobe handing the result to the register block
// ABORT    | one-cycle core flush after STOP or timeout

module acc_seq_ctrl #(
    parameter int IN_WIDTH    = 1024,
    parameter int OUT_WIDTH   = 32,
    parameter int CHUNK_W     = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [IN_WIDTH-1:0]  in_data_reg,
    output logic                 core_in_valid,
    input  logic                 core_in_ready,
    output logic [CHUNK_W-1:0]   core_in_data,
    output logic                 core_in_last,
    input  logic                 core_res_valid,
    output logic                 core_res_ready,
    input  logic [OUT_WIDTH-1:0] core_res_data,
    output logic                 core_clear,
    output logic                 out_data_cap_en,
    output logic [OUT_WIDTH-1:0] acc_out_data,
    output logic                 seq_busy,
    output logic                 timeout_err
);

    localparam int N_BEATS = IN_WIDTH / CHUNK_W;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_RES,
        S_CAPTURE,
        S_ABORT
    } state_t;

    state_t state_q, state_d;

    logic                              start_q;
    logic [N_BEATS-1:0][CHUNK_W-1:0]   snap_q;
    logic [BEAT_W-1:0]                 beat_q;
    logic [TMO_W-1:0]                  tmo_q;

    logic launch;
    logic beat_last;
    logic tmo_last;

    assign launch    = (state_q == S_IDLE) & start & ~start_q & ~stop;
    assign beat_last = (beat_q == LAST_BEAT);
    assign tmo_last  = (tmo_q == TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. STOP is tested first in every busy state so
    // it wins over beat acceptance, result acceptance and timeout.
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        core_in_valid   = 1'b0;
        core_in_data    = '0;
        core_in_last    = 1'b0;
        core_res_ready  = 1'b0;
        core_clear      = 1'b0;
        out_data_cap_en = 1'b0;
        seq_busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                core_in_valid = 1'b1;
                core_in_data  = snap_q[beat_q];
                core_in_last  = beat_last;
                if (stop) begin
                    state_d = S_ABORT;
                end else if (core_in_ready && beat_last) begin
                    state_d = S_WAIT_RES;
                end
            end

            S_WAIT_RES: begin
                core_res_ready = 1'b1;
                if (stop) begin
                    state_d = S_ABORT;
                end else if (core_res_valid) begin
                    state_d = S_CAPTURE;
                end else if (tmo_last) begin
                    state_d = S_ABORT;
                end
            end

            S_CAPTURE: begin
                out_data_cap_en = 1'b1;
                if (stop) begin
                    state_d = S_ABORT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ABORT: begin
                // Already flushing; a held STOP must not stretch the pulse.
                core_clear = 1'b1;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: start edge detect, snapshot, beat/timeout counters,
    // result register and sticky timeout flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            snap_q       <= '0;
            beat_q       <= '0;
            tmo_q        <= '0;
            acc_out_data <= '0;
            timeout_err  <= 1'b0;
        end else begin
            start_q <= start;

            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        snap_q      <= in_data_reg;
                        beat_q      <= '0;
                        timeout_err <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (!stop && core_in_ready) begin
                        if (beat_last) begin
                            tmo_q <= '0;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end

                S_WAIT_RES: begin
                    if (!stop) begin
                        if (core_res_valid) begin
                            acc_out_data <= core_res_data;
                        end else if (tmo_last) begin
                            timeout_err <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_acc_seq_ctrl
//
// Directed bench for acc_seq_ctrl (IN_WIDTH=1024, CHUNK_W=64, TIMEOUT_CYC=8).
// Expected beats and results are queued when a job or a core result is driven
// and popped when the sequencer presents a beat or strobes a capture.
// -----------------------------------------------------------------------------

module tb_acc_seq_ctrl;

    localparam int IN_WIDTH  = 1024;
    localparam int OUT_WIDTH = 32;
    localparam int CHUNK_W   = 64;
    localparam int N_BEATS   = IN_WIDTH / CHUNK_W;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 stop;
    logic [IN_WIDTH-1:0]  in_data_reg;
    logic                 core_in_valid;
    logic                 core_in_ready;
    logic [CHUNK_W-1:0]   core_in_data;
    logic                 core_in_last;
    logic                 core_res_valid;
    logic                 core_res_ready;
    logic [OUT_WIDTH-1:0] core_res_data;
    logic                 core_clear;
    logic                 out_data_cap_en;
    logic [OUT_WIDTH-1:0] acc_out_data;
    logic                 seq_busy;
    logic                 timeout_err;

    acc_seq_ctrl #(
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .CHUNK_W    (CHUNK_W),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .in_data_reg    (in_data_reg),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_in_data   (core_in_data),
        .core_in_last   (core_in_last),
        .core_res_valid (core_res_valid),
        .core_res_ready (core_res_ready),
        .core_res_data  (core_res_data),
        .core_clear     (core_clear),
        .out_data_cap_en(out_data_cap_en),
        .acc_out_data   (acc_out_data),
        .seq_busy       (seq_busy),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int cap_cnt;
    int clr_cnt;

    logic [CHUNK_W:0]     beat_q[$];
    logic [OUT_WIDTH-1:0] res_q[$];
    logic [OUT_WIDTH-1:0] exp_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: inputs and outputs are stable here.
    task automatic monitor();
        logic [CHUNK_W:0]     eb;
        logic [OUT_WIDTH-1:0] er;
        if (core_in_valid) begin
            if (beat_q.size() == 0) begin
                chk("extra_beat", 128'(core_in_valid), 128'(1'b0));
            end else begin
                eb = beat_q[0];
                chk("beat_data_last", 128'({core_in_last, core_in_data}), 128'(eb));
                if (core_in_ready) void'(beat_q.pop_front());
            end
        end
        if (out_data_cap_en) begin
            cap_cnt++;
            if (res_q.size() == 0) begin
                chk("unexpected_cap", 128'(out_data_cap_en), 128'(1'b0));
            end else begin
                er = res_q.pop_front();
                chk("acc_out_at_cap", 128'(acc_out_data), 128'(er));
            end
        end
        if (core_clear) clr_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_WIDTH-1:0] pat(input logic [63:0] base);
        logic [IN_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < N_BEATS; i++) r[i*CHUNK_W +: CHUNK_W] = base + 64'(i);
        return r;
    endfunction

    task automatic push_job(input logic [IN_WIDTH-1:0] d);
        for (int i = 0; i < N_BEATS; i++)
            beat_q.push_back({(i == N_BEATS - 1), d[i*CHUNK_W +: CHUNK_W]});
    endtask

    task automatic launch(input logic [IN_WIDTH-1:0] d);
        in_data_reg = d;
        push_job(d);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_res_ready();
        int k;
        k = 0;
        while (!core_res_ready && k < 200) begin
            step();
            k++;
        end
        chk("reach_wait_res", 128'(core_res_ready), 128'(1'b1));
        chk("beats_drained", 128'(beat_q.size()), 128'(0));
    endtask

    task automatic give_result(input logic [OUT_WIDTH-1:0] r);
        core_res_data  = r;
        core_res_valid = 1'b1;
        res_q.push_back(r);
        exp_acc = r;
        step();
        core_res_valid = 1'b0;
        step();
    endtask

    logic [IN_WIDTH-1:0] d;
    int k;

    initial begin
        n_checks = 0; n_fail = 0; cap_cnt = 0; clr_cnt = 0; exp_acc = '0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_data_reg = '0;
        core_in_ready = 1'b0; core_res_valid = 1'b0; core_res_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_in_valid", 128'(core_in_valid), 128'(0));
        chk("rst_in_data", 128'(core_in_data), 128'(0));
        chk("rst_in_last", 128'(core_in_last), 128'(0));
        chk("rst_res_ready", 128'(core_res_ready), 128'(0));
        chk("rst_clear", 128'(core_clear), 128'(0));
        chk("rst_cap", 128'(out_data_cap_en), 128'(0));
        chk("rst_acc", 128'(acc_out_data), 128'(0));
        chk("rst_busy", 128'(seq_busy), 128'(0));
        chk("rst_terr", 128'(timeout_err), 128'(0));
        rst_n = 1'b1;
        step();

        // Nominal job
        core_in_ready = 1'b1;
        launch(pat(64'd0));
        chk("busy_after_launch", 128'(seq_busy), 128'(1));
        wait_res_ready();
        give_result(32'hA5A5_0001);
        chk("nom_cap_cnt", 128'(cap_cnt), 128'(1));
        chk("nom_idle", 128'(seq_busy), 128'(0));
        chk("nom_acc", 128'(acc_out_data), 128'(exp_acc));

        // Backpressure: ready toggles every cycle
        core_in_ready = 1'b0;
        launch(pat(64'h100));
        k = 0;
        while (beat_q.size() > 0 && k < 200) begin
            core_in_ready = ~core_in_ready;
            step();
            k++;
        end
        core_in_ready = 1'b1;
        wait_res_ready();
        give_result(32'h1234_5678);
        chk("bp_cap_cnt", 128'(cap_cnt), 128'(2));
        chk("bp_acc", 128'(acc_out_data), 128'(exp_acc));

        // Snapshot: host rewrites input while beat 3 is presented
        d = pat(64'hC0DE_0000_0000_0000);
        launch(d);
        repeat (3) step();
        in_data_reg = ~d;
        wait_res_ready();
        give_result(32'h0BAD_F00D);
        chk("snap_cap_cnt", 128'(cap_cnt), 128'(3));

        // Timeout: no result for 8 cycles
        launch(pat(64'h5));
        wait_res_ready();
        k = 0;
        while (!timeout_err && k < 50) begin
            step();
            k++;
        end
        chk("tmo_cycles", 128'(k), 128'(8));
        chk("tmo_clear_pulse", 128'(core_clear), 128'(1));
        chk("tmo_no_cap", 128'(out_data_cap_en), 128'(0));
        step();
        chk("tmo_clear_once", 128'(core_clear), 128'(0));
        chk("tmo_idle", 128'(seq_busy), 128'(0));
        chk("tmo_clr_cnt", 128'(clr_cnt), 128'(1));
        chk("tmo_sticky", 128'(timeout_err), 128'(1));
        chk("tmo_cap_cnt", 128'(cap_cnt), 128'(3));

        // Next launch clears timeout_err; stop during beat 5
        launch(pat(64'h50));
        chk("terr_cleared", 128'(timeout_err), 128'(0));
        repeat (5) step();
        stop = 1'b1;
        step();
        beat_q.delete();
        chk("stop_beat_abort", 128'(core_clear), 128'(1));
        step();
        stop = 1'b0;
        chk("stop_beat_idle", 128'(seq_busy), 128'(0));
        chk("stop_beat_clr", 128'(clr_cnt), 128'(2));
        chk("stop_beat_acc", 128'(acc_out_data), 128'(exp_acc));

        // Stop in the same cycle as the result: result dropped
        launch(pat(64'h7));
        wait_res_ready();
        core_res_data = 32'hDEAD_BEEF;
        core_res_valid = 1'b1;
        stop = 1'b1;
        step();
        core_res_valid = 1'b0;
        stop = 1'b0;
        chk("stop_res_abort", 128'(core_clear), 128'(1));
        chk("stop_res_acc", 128'(acc_out_data), 128'(exp_acc));
        step();
        chk("stop_res_idle", 128'(seq_busy), 128'(0));
        chk("stop_res_cap_cnt", 128'(cap_cnt), 128'(3));

        // Stop in IDLE has no effect
        stop = 1'b1;
        step();
        chk("stop_idle_busy", 128'(seq_busy), 128'(0));
        chk("stop_idle_clr", 128'(clr_cnt), 128'(3));
        stop = 1'b0;
        step();

        // Minimum latency with result already valid, start held high
        in_data_reg = pat(64'h9);
        push_job(in_data_reg);
        core_res_data = 32'h5555_AAAA;
        core_res_valid = 1'b1;
        res_q.push_back(32'h5555_AAAA);
        exp_acc = 32'h5555_AAAA;
        start = 1'b1;
        k = 0;
        while (!out_data_cap_en && k < 100) begin
            step();
            k++;
        end
        chk("min_latency", 128'(k), 128'(N_BEATS + 2));
        core_res_valid = 1'b0;
        step();
        repeat (20) step();
        chk("level_no_relaunch", 128'(seq_busy), 128'(0));
        chk("level_cap_cnt", 128'(cap_cnt), 128'(4));

        // Drop and re-raise start: new job
        start = 1'b0;
        step();
        launch(pat(64'h11));
        wait_res_ready();
        give_result(32'h0000_0042);
        chk("relaunch_cap_cnt", 128'(cap_cnt), 128'(5));
        chk("relaunch_acc", 128'(acc_out_data), 128'(exp_acc));

        // Asynchronous reset mid-job: immediate IDLE, no flush pulse
        launch(pat(64'h3));
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(seq_busy), 128'(0));
        chk("arst_valid", 128'(core_in_valid), 128'(0));
        chk("arst_acc", 128'(acc_out_data), 128'(0));
        beat_q.delete();
        exp_acc = '0;
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        chk("arst_no_clear", 128'(clr_cnt), 128'(3));
        chk("arst_idle", 128'(seq_busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Accelerator-side sequencer that sits behind the host-facing datapath register block.
- Consumes the START/STOP control levels and the 1024-bit input data register.
- Streams the input word to the TM core in CHUNK_W-bit beats using a valid/ready handshake, then waits for the core result.
- Returns the result to the register block as a single-cycle capture strobe plus data; that strobe sets DONE and clears BUSY there.

Parameters:
- IN_WIDTH, 1024, width of the host input data register.
- OUT_WIDTH, 32, width of the result returned to the register block.
- CHUNK_W, 64, beat width to the core; IN_WIDTH must be an integer multiple of CHUNK_W.
- TIMEOUT_CYC, 4096, maximum cycles allowed in WAIT_RES; must be at least 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  START level from the control register
- stop  input  1  STOP level from the control register
- in_data_reg  input  IN_WIDTH  host input data
- core_in_valid  output  1  beat valid to the core
- core_in_ready  input  1  core accepts the beat
- core_in_data  output  CHUNK_W  current beat
- core_in_last  output  1  marks the final beat
- core_res_valid  input  1  core result valid
- core_res_ready  output  1  sequencer accepts the result
- core_res_data  input  OUT_WIDTH  core result
- core_clear  output  1  one-cycle core flush pulse
- out_data_cap_en  output  1  one-cycle capture strobe to the register block
- acc_out_data  output  OUT_WIDTH  result to the register block
- seq_busy  output  1  high whenever the FSM is not in IDLE
- timeout_err  output  1  sticky timeout flag

Behaviour:
- Reset: every output is 0; the FSM is in IDLE; start_q, the beat counter, the timeout counter and the snapshot buffer are 0.
- Start detection: start_q registers start every cycle. A launch is start & ~start_q & ~stop, evaluated only in IDLE. A start that stays high does not relaunch. A rising edge seen outside IDLE is ignored.
- IDLE to LOAD on launch:
  - in_data_reg is copied into an internal snapshot the same cycle, so later host writes do not affect the running job.
  - The beat counter is set to 0 and timeout_err is cleared.
- LOAD:
  - core_in_valid=1 and core_in_data = snapshot[beat*CHUNK_W +: CHUNK_W], LSB slice first.
  - core_in_last=1 when beat = IN_WIDTH/CHUNK_W-1.
  - The beat advances only on valid&ready. Data and last stay stable while ready is low.
  - When the last beat is accepted, go to WAIT_RES and set the timeout counter to 0.
- WAIT_RES:
  - core_res_ready=1.
  - On core_res_valid, latch core_res_data into acc_out_data and go to CAPTURE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYC-1 without a valid result, set timeout_err and go to ABORT.
- CAPTURE: out_data_cap_en=1 for exactly one cycle, then go to IDLE. acc_out_data holds its value until the next capture or reset.
- ABORT: core_clear=1 for exactly one cycle, then go to IDLE. There is no capture strobe, so the register block stays BUSY until the host writes STOP.
- Stop: stop high in any non-IDLE state forces ABORT on the next edge.
  - It has priority over beat acceptance, result acceptance and timeout.
  - A result arriving in the same cycle as stop is dropped; acc_out_data is not updated.
  - Stop in IDLE has no effect.
- timeout_err stays set until the next launch or reset.
- Reset mid-operation: the asynchronous reset returns everything to IDLE immediately; no core_clear pulse is produced.
- Latency: launch cycle, then N beats (N = IN_WIDTH/CHUNK_W, 16 at defaults) with ready held high, then result wait, then one capture cycle.
  - Minimum start-edge to out_data_cap_en with core_res_valid already high is N+2 cycles.

Test Plan:
- Nominal job: in_data_reg = beat index replicated per 64-bit slice, ready=1, result 32'hA5A5_0001 one cycle after last -> 16 beats with data 0..15, last only on beat 15, a single out_data_cap_en, acc_out_data=32'hA5A5_0001.
- Backpressure: ready toggles every other cycle -> no beat is lost or duplicated, data stays stable while stalled, total 16 accepted beats.
- Snapshot: host rewrites in_data_reg during beat 3 -> all beats carry the original snapshot values.
- Timeout: TIMEOUT_CYC=8 and no result -> timeout_err=1 after 8 cycles in WAIT_RES, one core_clear pulse, no strobe; the next launch clears timeout_err.
- Stop: stop asserted during beat 5, and separately in the same cycle as core_res_valid -> ABORT then IDLE, no out_data_cap_en, acc_out_data unchanged.
- Level start: start held high after completion -> no second job; dropping start and raising it again launches a new job.
